// File: rtl/alu_wb_stage_pkg.sv
// Shared constants and helpers for the ALU writeback/commit stage.
package alu_wb_stage_pkg;

  // CR source select
  localparam logic [1:0] CR_SEL_ADD  = 2'd0;
  localparam logic [1:0] CR_SEL_CMP  = 2'd1;
  localparam logic [1:0] CR_SEL_CMPL = 2'd2;
  localparam logic [1:0] CR_SEL_NONE = 2'd3;

  // XER bit indices inside the 3-bit {SO, OV, CA} vector
  localparam int XER_SO = 2;
  localparam int XER_OV = 1;
  localparam int XER_CA = 0;

  // Bit positions inside a 4-bit CR field
  localparam int CRF_LT = 3;
  localparam int CRF_GT = 2;
  localparam int CRF_EQ = 1;
  localparam int CRF_SO = 0;

  // Field 0 is the most significant nibble, so field bf has its LSB at 28 - 4*bf.
  function automatic logic [4:0] cr_field_lsb(input logic [2:0] bf);
    return 5'd28 - {bf, 2'b00};
  endfunction

endpackage

// File: rtl/alu_wb_stage_cr_field_gen.sv
// Builds a 4-bit CR field {LT, GT, EQ, SO} from the selected ALU flag pair.
// Also used by the compare-immediate path, so it has no state of its own.
module cr_field_gen
  import alu_wb_stage_pkg::*;
(
  input  logic [1:0] cr_sel,
  input  logic [1:0] add_cr,
  input  logic [1:0] cmp_cr,
  input  logic [1:0] cmpl_cr,
  input  logic       so_in,
  output logic       field_valid,
  output logic [3:0] field
);

  logic [1:0] pair;

  // Select the flag pair, then expand {a, b} into LT/GT/EQ with GT = neither.
  always_comb begin
    pair        = 2'b00;
    field_valid = 1'b1;
    unique case (cr_sel)
      CR_SEL_ADD:  pair = add_cr;
      CR_SEL_CMP:  pair = cmp_cr;
      CR_SEL_CMPL: pair = cmpl_cr;
      default:     field_valid = 1'b0;
    endcase
    field         = 4'b0000;
    field[CRF_LT] = pair[1];
    field[CRF_GT] = ~pair[1] & ~pair[0];
    field[CRF_EQ] = pair[0];
    field[CRF_SO] = so_in;
  end

endmodule

// File: rtl/alu_wb_stage.sv
// Writeback/commit stage after the ALU: one-entry GPR writeback register with
// valid/ready handshake, architectural XER[SO,OV,CA] and CR ownership.
module alu_wb_stage
  import alu_wb_stage_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int RADDR = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [RADDR-1:0] in_rt,
  input  logic             in_wr_rt,
  input  logic             in_rc,
  input  logic [1:0]       in_cr_sel,
  input  logic [2:0]       in_bf,
  input  logic             in_oe,
  input  logic             in_set_ca,
  input  logic [XLEN-1:0]  in_result,
  input  logic [1:0]       in_add_cr,
  input  logic [1:0]       in_cmp_cr,
  input  logic [1:0]       in_cmpl_cr,
  input  logic             in_ca,
  input  logic             in_ov,
  input  logic             flush,
  input  logic             xer_wr_en,
  input  logic [2:0]       xer_wr_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RADDR-1:0] out_rt,
  output logic [XLEN-1:0]  out_data,
  output logic [2:0]       xer,
  output logic             xer_ca,
  output logic [31:0]      cr
);

  logic             accept;
  logic [2:0]       xer_op;
  logic [2:0]       xer_next;
  logic             so_for_cr;
  logic             crf_valid;
  logic [3:0]       crf;
  logic [4:0]       crf_lsb;
  logic [31:0]      cr_next;
  logic             out_valid_next;
  logic [RADDR-1:0] out_rt_next;
  logic [XLEN-1:0]  out_data_next;

  // An mtxer write takes the cycle, so op-driven XER updates never collide with it.
  assign in_ready = reset_n & (~out_valid | out_ready) & ~xer_wr_en;
  assign accept   = in_valid & in_ready & ~flush;
  assign xer_ca   = xer[XER_CA];

  // XER value an accepted op would produce; SO is sticky on overflow.
  always_comb begin
    xer_op = xer;
    if (in_set_ca) xer_op[XER_CA] = in_ca;
    if (in_oe) begin
      xer_op[XER_OV] = in_ov;
      xer_op[XER_SO] = xer[XER_SO] | in_ov;
    end
  end

  // Adds record the post-update SO; compares record the SO already in XER.
  assign so_for_cr = (in_cr_sel == CR_SEL_ADD) ? xer_op[XER_SO] : xer[XER_SO];

  cr_field_gen u_cr_field_gen (
    .cr_sel      (in_cr_sel),
    .add_cr      (in_add_cr),
    .cmp_cr      (in_cmp_cr),
    .cmpl_cr     (in_cmpl_cr),
    .so_in       (so_for_cr),
    .field_valid (crf_valid),
    .field       (crf)
  );

  assign crf_lsb = cr_field_lsb(in_bf);

  // Next XER: explicit mtxer wins (flush does not block it), else accepted op.
  always_comb begin
    xer_next = xer;
    if (xer_wr_en)   xer_next = xer_wr_data;
    else if (accept) xer_next = xer_op;
  end

  // Next CR: replace only the addressed field, and only for record forms.
  always_comb begin
    cr_next = cr;
    if (accept && in_rc && crf_valid)
      cr_next = (cr & ~(32'hF << crf_lsb)) | ({28'd0, crf} << crf_lsb);
  end

  // Next writeback register: flush kills, accept loads, drain clears valid.
  always_comb begin
    out_valid_next = out_valid;
    out_rt_next    = out_rt;
    out_data_next  = out_data;
    if (flush) begin
      out_valid_next = 1'b0;
    end else if (accept && in_wr_rt) begin
      out_valid_next = 1'b1;
      out_rt_next    = in_rt;
      out_data_next  = in_result;
    end else if (out_ready) begin
      out_valid_next = 1'b0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_rt    <= '0;
      out_data  <= '0;
      xer       <= 3'b000;
      cr        <= 32'd0;
    end else begin
      out_valid <= out_valid_next;
      out_rt    <= out_rt_next;
      out_data  <= out_data_next;
      xer       <= xer_next;
      cr        <= cr_next;
    end
  end

endmodule

// File: tb/tb_alu_wb_stage.sv
// Directed self-checking bench for alu_wb_stage.
module tb_alu_wb_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rt;
  logic        in_wr_rt;
  logic        in_rc;
  logic [1:0]  in_cr_sel;
  logic [2:0]  in_bf;
  logic        in_oe;
  logic        in_set_ca;
  logic [31:0] in_result;
  logic [1:0]  in_add_cr;
  logic [1:0]  in_cmp_cr;
  logic [1:0]  in_cmpl_cr;
  logic        in_ca;
  logic        in_ov;
  logic        flush;
  logic        xer_wr_en;
  logic [2:0]  xer_wr_data;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_rt;
  logic [31:0] out_data;
  logic [2:0]  xer;
  logic        xer_ca;
  logic [31:0] cr;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  alu_wb_stage #(.XLEN(32), .RADDR(5)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_rt       (in_rt),
    .in_wr_rt    (in_wr_rt),
    .in_rc       (in_rc),
    .in_cr_sel   (in_cr_sel),
    .in_bf       (in_bf),
    .in_oe       (in_oe),
    .in_set_ca   (in_set_ca),
    .in_result   (in_result),
    .in_add_cr   (in_add_cr),
    .in_cmp_cr   (in_cmp_cr),
    .in_cmpl_cr  (in_cmpl_cr),
    .in_ca       (in_ca),
    .in_ov       (in_ov),
    .flush       (flush),
    .xer_wr_en   (xer_wr_en),
    .xer_wr_data (xer_wr_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_rt      (out_rt),
    .out_data    (out_data),
    .xer         (xer),
    .xer_ca      (xer_ca),
    .cr          (cr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic clear_in();
    in_valid   = 1'b0;
    in_rt      = '0;
    in_wr_rt   = 1'b0;
    in_rc      = 1'b0;
    in_cr_sel  = 2'd0;
    in_bf      = 3'd0;
    in_oe      = 1'b0;
    in_set_ca  = 1'b0;
    in_result  = '0;
    in_add_cr  = 2'b00;
    in_cmp_cr  = 2'b00;
    in_cmpl_cr = 2'b00;
    in_ca      = 1'b0;
    in_ov      = 1'b0;
    flush      = 1'b0;
    xer_wr_en  = 1'b0;
    xer_wr_data = 3'b000;
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clear_in();
    out_ready = 1'b1;
    reset_n   = 1'b0;
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    cyc();
    cyc();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_xer", {29'd0, xer}, 32'd0);
    chk("rst_cr", cr, 32'd0);
    reset_n = 1'b1;

    // add, rc, bf=0, positive non-zero result -> GT
    in_valid = 1; in_wr_rt = 1; in_rt = 5'd5; in_result = 32'h0000_0010;
    in_rc = 1; in_cr_sel = 2'd0; in_bf = 3'd0; in_add_cr = 2'b00;
    #1;
    chk("t1_in_ready", {31'd0, in_ready}, 32'd1);
    cyc();
    clear_in();
    chk("t1_out_valid", {31'd0, out_valid}, 32'd1);
    chk("t1_out_rt", {27'd0, out_rt}, 32'd5);
    chk("t1_out_data", out_data, 32'd16);
    chk("t1_cr", cr, 32'h4000_0000);
    chk("t1_xer", {29'd0, xer}, 32'd0);

    // addo. with overflow and carry, negative result, bf=7
    in_valid = 1; in_wr_rt = 1; in_rt = 5'd6; in_result = 32'h8000_0000;
    in_rc = 1; in_cr_sel = 2'd0; in_bf = 3'd7; in_add_cr = 2'b10;
    in_oe = 1; in_ov = 1; in_set_ca = 1; in_ca = 1;
    cyc();
    clear_in();
    chk("t2_xer", {29'd0, xer}, 32'd7);
    chk("t2_xer_ca", {31'd0, xer_ca}, 32'd1);
    chk("t2_cr", cr, 32'h4000_0009);
    chk("t2_out_rt", {27'd0, out_rt}, 32'd6);

    // oe op without overflow: OV clears, SO stays sticky
    in_valid = 1; in_wr_rt = 1; in_rt = 5'd7; in_result = 32'h0000_1234;
    in_oe = 1; in_ov = 0;
    cyc();
    clear_in();
    chk("t3_xer", {29'd0, xer}, 32'd5);
    chk("t3_cr", cr, 32'h4000_0009);

    // cmp, bf=3, eq, SO=1; other pairs set to distinct values
    in_valid = 1; in_wr_rt = 0; in_rc = 1; in_cr_sel = 2'd1; in_bf = 3'd3;
    in_cmp_cr = 2'b01; in_cmpl_cr = 2'b10; in_add_cr = 2'b11;
    cyc();
    clear_in();
    chk("t4_cr", cr, 32'h4003_0009);
    chk("t4_xer", {29'd0, xer}, 32'd5);
    chk("t4_out_valid", {31'd0, out_valid}, 32'd0);

    // cmpl, bf=1, lt
    in_valid = 1; in_rc = 1; in_cr_sel = 2'd2; in_bf = 3'd1;
    in_cmp_cr = 2'b01; in_cmpl_cr = 2'b10; in_add_cr = 2'b01;
    cyc();
    clear_in();
    chk("t5_cr_cmpl", cr, 32'h4903_0009);

    // reserved select: no CR write
    in_valid = 1; in_rc = 1; in_cr_sel = 2'd3; in_bf = 3'd2; in_cmp_cr = 2'b10;
    cyc();
    clear_in();
    chk("t6_cr_none", cr, 32'h4903_0009);

    // backpressure: hold A for 3 cycles, B waits and follows with no gap
    out_ready = 0;
    in_valid = 1; in_wr_rt = 1; in_rt = 5'd9; in_result = 32'hAAAA_5555;
    cyc();
    chk("t7_a_valid", {31'd0, out_valid}, 32'd1);
    in_rt = 5'd10; in_result = 32'h0000_0BBB;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t7_stall_ready", {31'd0, in_ready}, 32'd0);
      cyc();
      chk("t7_hold_data", out_data, 32'hAAAA_5555);
      chk("t7_hold_rt", {27'd0, out_rt}, 32'd9);
    end
    out_ready = 1;
    #1;
    chk("t7_ready_rise", {31'd0, in_ready}, 32'd1);
    cyc();
    clear_in();
    chk("t7_b_valid", {31'd0, out_valid}, 32'd1);
    chk("t7_b_data", out_data, 32'h0000_0BBB);
    chk("t7_b_rt", {27'd0, out_rt}, 32'd10);
    cyc();
    chk("t7_drained", {31'd0, out_valid}, 32'd0);

    // flush drops an accepting op entirely
    in_valid = 1; in_wr_rt = 1; in_rt = 5'd3; in_result = 32'h0000_00FF;
    in_oe = 1; in_ov = 1; in_set_ca = 1; in_ca = 0;
    in_rc = 1; in_cr_sel = 2'd0; in_bf = 3'd0; in_add_cr = 2'b01; flush = 1;
    cyc();
    clear_in();
    chk("t8_out_valid", {31'd0, out_valid}, 32'd0);
    chk("t8_xer", {29'd0, xer}, 32'd5);
    chk("t8_cr", cr, 32'h4903_0009);

    // flush kills a held writeback
    out_ready = 0;
    in_valid = 1; in_wr_rt = 1; in_rt = 5'd2; in_result = 32'h0000_0022;
    cyc();
    clear_in();
    flush = 1;
    cyc();
    clear_in();
    out_ready = 1;
    chk("t9_flush_held", {31'd0, out_valid}, 32'd0);

    // mtxer blocks the op for one cycle, then the op is accepted
    xer_wr_en = 1; xer_wr_data = 3'b001;
    in_valid = 1; in_wr_rt = 1; in_rt = 5'd4; in_result = 32'h0000_0044;
    in_set_ca = 1; in_ca = 0; in_oe = 1; in_ov = 1;
    #1;
    chk("t10_ready_blk", {31'd0, in_ready}, 32'd0);
    cyc();
    chk("t10_xer", {29'd0, xer}, 32'd1);
    chk("t10_xer_ca", {31'd0, xer_ca}, 32'd1);
    chk("t10_no_wb", {31'd0, out_valid}, 32'd0);
    xer_wr_en = 0;
    #1;
    chk("t10_ready", {31'd0, in_ready}, 32'd1);
    cyc();
    clear_in();
    chk("t10_xer_op", {29'd0, xer}, 32'd6);
    chk("t10_wb_data", out_data, 32'h0000_0044);
    chk("t10_wb_rt", {27'd0, out_rt}, 32'd4);

    // reset mid-operation discards the held writeback and clears state
    out_ready = 0;
    in_valid = 1; in_wr_rt = 1; in_rt = 5'd8; in_result = 32'h0000_0088;
    cyc();
    clear_in();
    chk("t11_held", {31'd0, out_valid}, 32'd1);
    reset_n = 0;
    #1;
    chk("t11_rst_ready", {31'd0, in_ready}, 32'd0);
    cyc();
    chk("t11_out_valid", {31'd0, out_valid}, 32'd0);
    chk("t11_xer", {29'd0, xer}, 32'd0);
    chk("t11_cr", cr, 32'd0);
    chk("t11_out_data", out_data, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/alu_wb_stage.md
Name: alu_wb_stage

Overview:
- Writeback/commit stage directly downstream of the 32-bit ALU.
- Consumes the ALU's result, CR-flag pairs (add/cmp/cmpl), carry and overflow, plus the decoded op control fields.
- Registers the GPR writeback with a valid/ready handshake and owns architectural XER[SO,OV,CA] and the 32-bit CR.
- Feeds XER[CA] back to the ALU cin.

Parameters:
- XLEN, 32, datapath width; must match the ALU.
- RADDR, 5, GPR address width.

Ports:
- clk  in  1  clock.
- reset_n  in  1  synchronous, active-low reset.
- in_valid  in  1  ALU op presented.
- in_ready  out  1  stage accepts op this cycle.
- in_rt  in  RADDR  destination GPR.
- in_wr_rt  in  1  op writes GPR.
- in_rc  in  1  record form: write CR field.
- in_cr_sel  in  2  0=add_cr, 1=cmp_cr, 2=cmpl_cr, 3=reserved (no CR write).
- in_bf  in  3  target CR field (0 = CR[31:28]).
- in_oe  in  1  update OV/SO.
- in_set_ca  in  1  update CA.
- in_result  in  XLEN  ALU result.
- in_add_cr  in  2  {neg, zero}.
- in_cmp_cr  in  2  {lt, eq}.
- in_cmpl_cr  in  2  {lt, eq}.
- in_ca  in  1  ALU carry.
- in_ov  in  1  ALU overflow.
- flush  in  1  kill held and accepting ops.
- xer_wr_en  in  1  mtxer write.
- xer_wr_data  in  3  {SO, OV, CA}.
- out_valid  out  1  GPR writeback valid.
- out_ready  in  1  register file accepts.
- out_rt  out  RADDR  writeback address.
- out_data  out  XLEN  writeback data.
- xer  out  3  {SO, OV, CA}, registered.
- xer_ca  out  1  = xer[0]; drives ALU cin.
- cr  out  32  architectural CR, registered.

Behaviour:
- Reset (reset_n low at clk edge):
  - out_valid=0, out_rt=0, out_data=0, xer=3'b000, cr=0.
  - in_ready=0 while reset_n is low.
- Handshake:
  - in_ready = reset_n & (!out_valid | out_ready) & !xer_wr_en.
  - Accept = in_valid & in_ready & !flush.
- Output register (one-entry, latency 1, full throughput):
  - Loads on Accept when in_wr_rt=1: out_valid←1, out_rt←in_rt, out_data←in_result.
  - Accept with in_wr_rt=0 leaves out_valid←0 if it was drained (out_ready) and loads nothing.
  - When out_valid & out_ready and no new load: out_valid←0.
  - While out_valid & !out_ready: out_rt/out_data held stable, in_ready=0.
- Flush:
  - out_valid←0 next cycle.
  - An op presented in the same cycle is dropped: no GPR, XER or CR update.
- XER update on Accept (new values computed combinationally, registered at edge):
  - CA←in_ca if in_set_ca.
  - OV←in_ov if in_oe.
  - SO←SO | in_ov if in_oe (sticky).
  - Unselected bits are unchanged.
- CR update on Accept when in_rc=1 and in_cr_sel≠3:
  - Field bf (bits [31-4bf : 28-4bf]) ← {LT, GT, EQ, SO'}, where (a,b) is the selected pair: LT=a, EQ=b, GT=!a&!b.
  - SO' is the post-update SO: the new sticky value for add ops with oe; current SO for compares (compares never set OV).
  - The other 7 fields are unchanged.
  - in_cr_sel=3 with in_rc=1: no CR write.
- xer_wr_en:
  - xer←xer_wr_data next edge.
  - Forces in_ready=0, so it never coincides with an op update.
  - Flush does not block it.
- Bypass: an op accepted in cycle N sees xer_ca as updated by the op accepted in cycle N-1; the ALU must be single-cycle.
- Reset mid-operation: a held writeback is discarded; XER and CR return to 0.

Decomposition:
- Shared package:
  - CR_SEL_ADD/CMP/CMPL/NONE constants.
  - XER bit indices SO=2, OV=1, CA=0.
  - CR field bit positions LT=3, GT=2, EQ=1, SO=0.
  - Function mapping bf to a CR bit offset.
- One sub-module: cr_field_gen (combinational). Takes cr_sel, the three flag pairs and so_in; returns the 4-bit field. It is reused by the compare-immediate path.

Test Plan:
- Reset then in_valid=1, in_wr_rt=1, rt=5, result=32'h0000_0010, rc=1, cr_sel=0, bf=0, add_cr=2'b00, oe=0 → next cycle out_valid=1, out_rt=5, out_data=16, cr=32'h4000_0000, xer=0.
- Add with oe=1, in_ov=1, in_set_ca=1, in_ca=1, rc=1, bf=7, add_cr=2'b10 → xer=3'b111 and cr[3:0]=4'b1001. A following op with oe=1, in_ov=0 → xer=3'b101, SO still 1.
- Compare cmp_cr=2'b01, cr_sel=1, bf=3, with SO=1 → cr[19:16]=4'b0011, XER unchanged, no GPR write (in_wr_rt=0, out_valid stays 0).
- out_ready=0 for 3 cycles with out_valid=1 → in_ready=0, out_data held. A second op waits and is accepted on the cycle out_ready rises; no gap is lost.
- flush in the same cycle as an accepting op with oe=1, ov=1 → out_valid=0 next cycle, xer and cr unchanged.
- xer_wr_en=1, data=3'b001 with in_valid=1 → in_ready=0, xer=3'b001, xer_ca=1 next cycle. The op is accepted the following cycle.
